// File: rtl/time_entry_ctrl_pkg.sv
// rtl/time_entry_ctrl_pkg.sv - shared state encoding, key codes and BCD field layout
package time_entry_ctrl_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] KEY_START    = 4'hA;
  localparam logic [3:0] KEY_CANCEL   = 4'hB;
  localparam logic [3:0] MAX_SEC_TENS = 4'd5;

  // Nibble offsets of each BCD digit within digits[15:0] ({min_t,min_u,sec_t,sec_u})
  localparam int MIN_T_LSB = 12;
  localparam int MIN_U_LSB = 8;
  localparam int SEC_T_LSB = 4;
  localparam int SEC_U_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic is_digit_key(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/time_entry_ctrl_buf.sv
// rtl/time_entry_ctrl_buf.sv - 4-digit BCD shift buffer with entry count, clear and full flag
module bcd_shift_buf
  import time_entry_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clear_n,
  input  logic        shift_en,
  input  logic [3:0]  shift_digit,
  input  logic        clr,
  output logic [15:0] digits,
  output logic [2:0]  count,
  output logic        full
);

  assign full = (count == 3'(NUM_DIGITS));

  // New digits enter at the seconds-units end, pushing earlier ones toward minutes
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      digits <= 16'h0;
      count  <= 3'd0;
    end else if (clr) begin
      digits <= 16'h0;
      count  <= 3'd0;
    end else if (shift_en && !full) begin
      digits <= {digits[11:0], shift_digit};
      count  <= count + 3'd1;
    end
  end

endmodule

// File: rtl/time_entry_ctrl.sv
// rtl/time_entry_ctrl.sv - keypad MM:SS entry, START validation and countdown run control
module time_entry_ctrl
  import time_entry_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clear_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        timer_zero,
  output logic [15:0] digits,
  output logic        load,
  output logic        run,
  output logic        done,
  output logic        err
);

  state_t     state_q, state_d;
  logic       load_d, run_d, done_d, err_d;
  logic       buf_shift, buf_clr, buf_full;
  logic [2:0] buf_count;
  logic       key_digit, key_start, key_cancel, start_ok;

  assign key_digit  = key_valid && is_digit_key(key_code);
  assign key_start  = key_valid && (key_code == KEY_START);
  assign key_cancel = key_valid && (key_code == KEY_CANCEL);

  // 00:00 cannot be cooked and seconds-tens above 5 is not a valid clock time
  assign start_ok = (buf_count != 3'd0) && (digits != 16'h0) &&
                    (digits[SEC_T_LSB +: 4] <= MAX_SEC_TENS);

  bcd_shift_buf u_buf (
    .clk         (clk),
    .clear_n     (clear_n),
    .shift_en    (buf_shift),
    .shift_digit (key_code),
    .clr         (buf_clr),
    .digits      (digits),
    .count       (buf_count),
    .full        (buf_full)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      load    <= 1'b0;
      run     <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      load    <= load_d;
      run     <= run_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_d    = 1'b0;
    run_d     = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    buf_shift = 1'b0;
    buf_clr   = 1'b0;
    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (key_digit) begin
          buf_shift = !buf_full;
          state_d   = ST_ENTRY;
        end else if (key_cancel) begin
          buf_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (key_start) begin
          if (start_ok) begin
            state_d = ST_LOAD;
            load_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
        run_d   = 1'b1;
      end
      ST_RUN: begin
        // Reaching zero wins over any key pressed in the same cycle
        if (timer_zero) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          buf_clr = 1'b1;
        end else if (key_cancel) begin
          state_d = ST_IDLE;
          buf_clr = 1'b1;
        end else begin
          run_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_time_entry_ctrl.sv
// tb/tb_time_entry_ctrl.sv - directed and randomized self-checking bench for time_entry_ctrl
module tb_time_entry_ctrl;

  logic        clk = 1'b0;
  logic        clear_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        timer_zero;
  logic [15:0] digits;
  logic        load, run, done, err;

  int checks = 0;
  int failures = 0;

  int q[$];
  bit m_run, m_loading, m_finishing;
  bit e_load, e_done, e_err;

  always #5 clk = ~clk;

  time_entry_ctrl dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .timer_zero (timer_zero),
    .digits     (digits),
    .load       (load),
    .run        (run),
    .done       (done),
    .err        (err)
  );

  function automatic logic [15:0] m_pack();
    logic [15:0] v = 16'h0;
    foreach (q[i]) v = {v[11:0], 4'(q[i])};
    return v;
  endfunction

  task automatic m_reset();
    q.delete();
    m_run = 0; m_loading = 0; m_finishing = 0;
    e_load = 0; e_done = 0; e_err = 0;
  endtask

  task automatic m_step(input bit kv, input logic [3:0] kc, input bit tz);
    logic [15:0] v;
    e_load = 0; e_done = 0; e_err = 0;
    if (m_run) begin
      if (tz) begin
        m_run = 0; e_done = 1; q.delete(); m_finishing = 1;
      end else if (kv && kc == 4'hB) begin
        m_run = 0; q.delete();
      end
    end else if (m_loading) begin
      m_loading = 0; m_run = 1;
    end else if (m_finishing) begin
      m_finishing = 0;
    end else if (kv) begin
      if (kc <= 4'd9) begin
        if (q.size() < 4) q.push_back(int'(kc));
      end else if (kc == 4'hB) begin
        q.delete();
      end else if (kc == 4'hA) begin
        v = m_pack();
        if (v == 16'h0 || v[7:4] > 4'd5) e_err = 1;
        else begin e_load = 1; m_loading = 1; end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_digits"}, digits, m_pack());
    chk({tag, "_load"}, 16'(load), 16'(e_load));
    chk({tag, "_run"}, 16'(run), 16'(m_run));
    chk({tag, "_done"}, 16'(done), 16'(e_done));
    chk({tag, "_err"}, 16'(err), 16'(e_err));
  endtask

  task automatic step(input bit kv, input logic [3:0] kc, input bit tz, input string tag);
    key_valid = kv; key_code = kc; timer_zero = tz;
    @(posedge clk);
    #1;
    m_step(kv, kc, tz);
    chk_all(tag);
    key_valid = 0; timer_zero = 0;
  endtask

  task automatic idle(input string tag);
    step(0, 4'h0, 0, tag);
  endtask

  initial begin
    logic [3:0] kc;
    bit kv, tz;
    int r;

    clear_n = 0; key_valid = 0; key_code = 0; timer_zero = 0;
    m_reset();
    #12;
    chk_all("reset");
    clear_n = 1;
    idle("post_reset");

    // 1,2,3 then START
    step(1, 4'h1, 0, "k1"); step(1, 4'h2, 0, "k2"); step(1, 4'h3, 0, "k3");
    chk("dir_0123", digits, 16'h0123);
    step(1, 4'hA, 0, "start123");
    chk("dir_load", 16'(load), 16'h1);
    idle("load_cycle");
    chk("dir_run", 16'(run), 16'h1);
    chk("dir_load_gone", 16'(load), 16'h0);
    step(0, 4'h0, 1, "tz123");
    idle("after_done123");

    // Five digits, fifth dropped, then CANCEL
    for (int i = 1; i <= 5; i++) step(1, 4'(i), 0, "k12345");
    chk("dir_1234", digits, 16'h1234);
    step(1, 4'hB, 0, "cancel_entry");
    chk("dir_cancel", digits, 16'h0000);

    // Invalid seconds tens rejected
    step(1, 4'h0, 0, "k0"); step(1, 4'h1, 0, "k1"); step(1, 4'h7, 0, "k7"); step(1, 4'h5, 0, "k5");
    step(1, 4'hA, 0, "start0175");
    chk("dir_err0175", 16'(err), 16'h1);
    chk("dir_keep0175", digits, 16'h0175);
    idle("after_err");
    step(1, 4'hB, 0, "cancel0175");

    // Empty START
    step(1, 4'hA, 0, "start_empty");
    chk("dir_err_empty", 16'(err), 16'h1);

    // 00:10 with zero on 3rd RUN cycle
    step(1, 4'h0, 0, "k0"); step(1, 4'h0, 0, "k0"); step(1, 4'h1, 0, "k1"); step(1, 4'h0, 0, "k0");
    step(1, 4'hA, 0, "start0010");
    idle("load0010");
    idle("run1"); idle("run2");
    step(0, 4'h0, 1, "run3_tz");
    chk("dir_done", 16'(done), 16'h1);
    chk("dir_done_digits", digits, 16'h0);
    idle("done_gone");

    // CANCEL together with timer_zero: done still pulses
    step(1, 4'h9, 0, "k9"); step(1, 4'hA, 0, "start9"); idle("load9");
    step(1, 4'hB, 1, "cancel_tz");
    chk("dir_done_prio", 16'(done), 16'h1);
    idle("after_prio");

    // CANCEL alone in RUN
    step(1, 4'h4, 0, "k4"); step(1, 4'hA, 0, "start4"); idle("load4");
    step(1, 4'h7, 0, "run_digit_ignored"); step(1, 4'hA, 0, "run_start_ignored");
    step(1, 4'hB, 0, "cancel_run");
    chk("dir_cancel_norun", 16'(run), 16'h0);
    chk("dir_cancel_nodone", 16'(done), 16'h0);

    // Async reset mid-RUN
    step(1, 4'h2, 0, "k2"); step(1, 4'hA, 0, "start2"); idle("load2"); idle("run_pre_rst");
    #2 clear_n = 0;
    #1;
    m_reset();
    chk("dir_async_run", 16'(run), 16'h0);
    chk_all("async_rst");
    #2 clear_n = 1;
    idle("post_rst2");

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      kv = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 19);
      if (r <= 9) kc = 4'(r);
      else if (r <= 12) kc = 4'hA;
      else if (r == 13) kc = 4'hB;
      else if (r <= 15) kc = 4'(r - 2);
      else kc = 4'(r - 16);
      tz = m_run ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 19) == 0);
      step(kv, kc, tz, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
